pwm_capture: RTL and testbench

- Measures the high time and period of one PWM waveform, counted in clk cycles. Typical sources are an RC receiver input or a loopback of a pwm_chan output.
- Sits directly downstream of the PWM generator channels. Results use the same 32-bit cycle units as the generator's period/hi inputs, so captured values can be compared against the commanded ones or forwarded unchanged.
- Includes an input synchronizer, edge detection, measurement FSM and loss-of-signal timeout.

---
 rtl/pwm_capture.sv | 127 ++++++++++++
 tb/tb_pwm_capture.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM capture: synchronizes an asynchronous PWM line and measures its high time and period
// in clk cycles. A loss-of-signal timeout covers a line stuck at either level.
module pwm_capture #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] TIMEOUT     = 32'd2_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        pwm_in,
  output logic [31:0] hi_out,
  output logic [31:0] period_out,
  output logic        sample_valid,
  output logic        signal_lost,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t            st, st_n;
  logic [SYNC_STAGES-1:0] sync_ff;
  logic              sync_q, sync_d;
  logic              rise, fall;
  logic [31:0]       cnt, cnt_n, cnt_inc;
  logic [31:0]       hi_latch, hi_latch_n;
  logic [31:0]       hi_n, period_n;
  logic              valid_n, lost_n;
  logic              timeout_hit;

  assign sync_q = sync_ff[SYNC_STAGES-1];
  assign rise   = sync_q & ~sync_d;
  assign fall   = ~sync_q & sync_d;
  assign state  = st;

  // Synchronizer runs independently of enable so a re-enable sees a settled line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_ff <= '0;
      sync_d  <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], pwm_in};
      sync_d  <= sync_q;
    end
  end

  assign cnt_inc     = (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  assign timeout_hit = (cnt == TIMEOUT);

  always_comb begin
    st_n       = st;
    cnt_n      = cnt;
    hi_latch_n = hi_latch;
    hi_n       = hi_out;
    period_n   = period_out;
    valid_n    = 1'b0;
    lost_n     = signal_lost;
    if (!enable) begin
      st_n   = IDLE;
      cnt_n  = 32'd0;
      lost_n = 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (rise) begin
            cnt_n = 32'd1;
            st_n  = HIGH;
          end
        end
        HIGH: begin
          cnt_n = cnt_inc;
          if (fall) begin
            hi_latch_n = cnt;
            st_n       = LOW;
          end else if (timeout_hit) begin
            lost_n = 1'b1;
            cnt_n  = 32'd0;
            st_n   = IDLE;
          end
        end
        LOW: begin
          cnt_n = cnt_inc;
          if (rise) begin
            period_n = cnt;
            hi_n     = hi_latch;
            valid_n  = 1'b1;
            lost_n   = 1'b0;
            cnt_n    = 32'd1;
            st_n     = HIGH;
          end else if (timeout_hit) begin
            lost_n = 1'b1;
            cnt_n  = 32'd0;
            st_n   = IDLE;
          end
        end
        default: begin
          st_n  = IDLE;
          cnt_n = 32'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st           <= IDLE;
      cnt          <= 32'd0;
      hi_latch     <= 32'd0;
      hi_out       <= 32'd0;
      period_out   <= 32'd0;
      sample_valid <= 1'b0;
      signal_lost  <= 1'b0;
    end else begin
      st           <= st_n;
      cnt          <= cnt_n;
      hi_latch     <= hi_latch_n;
      hi_out       <= hi_n;
      period_out   <= period_n;
      sample_valid <= valid_n;
      signal_lost  <= lost_n;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed PWM waveforms, expected (hi, period) pairs queued at each
// completing rise and checked by a monitor on every sample_valid strobe.
module tb_pwm_capture;

  localparam logic [31:0] TIMEOUT = 32'd100;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        pwm_in;
  logic [31:0] hi_out;
  logic [31:0] period_out;
  logic        sample_valid;
  logic        signal_lost;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_strobe_cyc = 0;
  int rise_cyc = 0;
  logic prev_valid = 1'b0;
  logic [63:0] exp_q[$];

  pwm_capture #(.SYNC_STAGES(2), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .pwm_in       (pwm_in),
    .hi_out       (hi_out),
    .period_out   (period_out),
    .sample_valid (sample_valid),
    .signal_lost  (signal_lost),
    .state        (state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got cyc=%0d required finish", cyc);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_high(input bit push, input logic [31:0] eh, input logic [31:0] ep);
    if (push) exp_q.push_back({eh, ep});
    pwm_in = 1'b1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset && sample_valid) begin
      checks++;
      if (prev_valid) begin
        errors++;
        $display("FAIL strobe_width: sample_valid high two cycles in a row at cyc %0d, required 1 cycle", cyc);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got hi=%0d period=%0d at cyc %0d, required no strobe",
                 hi_out, period_out, cyc);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({hi_out, period_out} !== e) begin
          errors++;
          $display("FAIL sample: got hi=%0d period=%0d required hi=%0d period=%0d",
                   hi_out, period_out, e[63:32], e[31:0]);
        end
      end
      last_strobe_cyc = cyc;
    end
    prev_valid = sample_valid;
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    pwm_in = 1'b0;
    tick(3);
    check("rst_hi", hi_out, 0);
    check("rst_period", period_out, 0);
    check("rst_valid", {31'd0, sample_valid}, 0);
    check("rst_lost", {31'd0, signal_lost}, 0);
    check("rst_state", {30'd0, state}, 0);
    reset = 1'b0;
    tick(2);
    enable = 1'b1;
    tick(2);

    // steady 10/40, five rises give four samples
    for (int i = 0; i < 5; i++) begin
      set_high(i > 0, 10, 40);
      if (i == 1) rise_cyc = cyc;
      tick(10);
      pwm_in = 1'b0;
      tick(30);
      if (i == 1) check("first_strobe_latency", last_strobe_cyc - rise_cyc, 3);
    end
    set_high(1, 10, 40);
    tick(5);
    check("pre_reset_state_high", {30'd0, state}, 1);

    // asynchronous reset mid HIGH
    #3;
    reset = 1'b1;
    #1;
    check("midrst_hi", hi_out, 0);
    check("midrst_period", period_out, 0);
    check("midrst_valid", {31'd0, sample_valid}, 0);
    check("midrst_lost", {31'd0, signal_lost}, 0);
    check("midrst_state", {30'd0, state}, 0);
    tick(2);
    reset = 1'b0;
    tick(10);
    check("post_reset_first_rise_state", {30'd0, state}, 1);
    pwm_in = 1'b0;
    enable = 1'b0;
    tick(5);
    check("disabled_state", {30'd0, state}, 0);
    enable = 1'b1;
    tick(2);

    // period change 5/20 -> 25/100 at a period boundary
    set_high(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(5);
      pwm_in = 1'b0;
      tick(15);
      set_high(1, 5, 20);
    end
    for (int i = 0; i < 2; i++) begin
      tick(25);
      pwm_in = 1'b0;
      tick(75);
      set_high(1, 25, 100);
    end

    // stuck high
    tick(90);
    check("stuck_high_not_yet_lost", {31'd0, signal_lost}, 0);
    tick(20);
    check("stuck_high_lost", {31'd0, signal_lost}, 1);
    check("stuck_high_state", {30'd0, state}, 0);
    check("stuck_high_hold_hi", hi_out, 25);
    check("stuck_high_hold_period", period_out, 100);

    // resume, then stuck low
    pwm_in = 1'b0;
    tick(20);
    set_high(0, 0, 0);
    tick(10);
    check("lost_held_at_first_rise", {31'd0, signal_lost}, 1);
    pwm_in = 1'b0;
    tick(30);
    set_high(1, 10, 40);
    tick(10);
    check("lost_cleared_by_sample", {31'd0, signal_lost}, 0);
    pwm_in = 1'b0;
    tick(80);
    check("stuck_low_not_yet_lost", {31'd0, signal_lost}, 0);
    tick(20);
    check("stuck_low_lost", {31'd0, signal_lost}, 1);
    check("stuck_low_state", {30'd0, state}, 0);
    check("stuck_low_hold_hi", hi_out, 10);
    check("stuck_low_hold_period", period_out, 40);
    set_high(0, 0, 0);
    tick(10);
    check("lost_after_rise", {31'd0, signal_lost}, 1);
    pwm_in = 1'b0;
    tick(30);
    set_high(1, 10, 40);
    tick(5);
    check("lost_cleared_again", {31'd0, signal_lost}, 0);

    // enable low for 50 cycles mid-period, PWM keeps running
    tick(5);
    pwm_in = 1'b0;
    tick(10);
    enable = 1'b0;
    tick(20);
    pwm_in = 1'b1;
    tick(10);
    pwm_in = 1'b0;
    tick(20);
    check("disabled_lost", {31'd0, signal_lost}, 0);
    check("disabled_idle", {30'd0, state}, 0);
    enable = 1'b1;
    tick(10);
    set_high(0, 0, 0);
    tick(10);
    pwm_in = 1'b0;
    tick(30);
    set_high(1, 10, 40);
    tick(10);
    check("reenable_strobe_seen", last_strobe_cyc > cyc - 10 ? 1 : 0, 1);

    tick(5);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
